// File: rtl/processor_fetch_queue.sv
// Instruction-fetch front end: prefetches code words from a 1-cycle synchronous
// code memory into a small queue and presents {ip, ip+1, word} to decode.
module processor_fetch_queue #(
  parameter int                   ADDR_SIZE = 18,
  parameter int                   WORD_SIZE = 18,
  parameter int                   DEPTH     = 4,
  parameter logic [ADDR_SIZE-1:0] RESET_IP  = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic [ADDR_SIZE-1:0]         code_addr,
  input  logic [WORD_SIZE-1:0]         code_word,
  input  logic                         hold,
  input  logic                         call_performed,
  input  logic [ADDR_SIZE-1:0]         ip_to_call,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_SIZE-1:0]         out_ip,
  output logic [ADDR_SIZE-1:0]         out_ip_plus_one,
  output logic [WORD_SIZE-1:0]         out_word,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [ADDR_SIZE-1:0] fetch_ip;
  logic [ADDR_SIZE-1:0] pend_ip;
  logic                 pend;
  logic [ADDR_SIZE-1:0] ip_mem   [DEPTH];
  logic [WORD_SIZE-1:0] word_mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [LVL_W-1:0]     count;
  logic [LVL_W:0]       occupied;
  logic                 issue;
  logic                 push;
  logic                 pop;

  // The address is forced during reset so memory never sees an undefined read.
  assign code_addr = reset          ? RESET_IP   :
                     call_performed ? ip_to_call : fetch_ip;

  // Space accounting includes the word still in flight, so a push never overflows.
  assign occupied = {1'b0, count} + (LVL_W+1)'(pend);
  assign issue    = !hold && (call_performed || (occupied < (LVL_W+1)'(DEPTH)));
  assign push     = pend && !call_performed;
  assign pop      = (count != '0) && out_ready && !call_performed;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_ip <= RESET_IP;
      pend     <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      pend <= issue;
      if (issue)
        fetch_ip <= code_addr + ADDR_SIZE'(1);
      else if (call_performed)
        fetch_ip <= ip_to_call;

      if (call_performed) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + LVL_W'(1);
          2'b01:   count <= count - LVL_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Datapath storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (issue)
      pend_ip <= code_addr;
    if (push) begin
      ip_mem[wr_ptr]   <= pend_ip;
      word_mem[wr_ptr] <= code_word;
    end
  end

  assign out_valid       = (count != '0);
  assign out_ip          = out_valid ? ip_mem[rd_ptr] : '0;
  assign out_ip_plus_one = out_valid ? ip_mem[rd_ptr] + ADDR_SIZE'(1) : '0;
  assign out_word        = out_valid ? word_mem[rd_ptr] : '0;
  assign level           = count;

endmodule

// File: tb/tb_processor_fetch_queue.sv
// Bench for processor_fetch_queue: two instances (RESET_IP 0 and 2^18-2) share
// the controls; a code memory model returns addr+100 one cycle after the read.
module tb_processor_fetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic        call_performed = 1'b0;
  logic [17:0] ip_to_call = '0;
  logic        out_ready = 1'b0;

  logic [17:0] code_addr1, code_word1, out_ip1, out_ip_plus_one1, out_word1;
  logic [17:0] code_addr2, code_word2, out_ip2, out_ip_plus_one2, out_word2;
  logic        out_valid1, out_valid2;
  logic [2:0]  level1, level2;

  int passed = 0;
  int total  = 0;
  logic [17:0] exp_q [$];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    code_word1 <= code_addr1 + 18'd100;
    code_word2 <= code_addr2 + 18'd100;
  end

  processor_fetch_queue #(.ADDR_SIZE(18), .WORD_SIZE(18), .DEPTH(4), .RESET_IP(18'h00000)) dut1 (
    .clock(clock), .reset(reset), .code_addr(code_addr1), .code_word(code_word1),
    .hold(hold), .call_performed(call_performed), .ip_to_call(ip_to_call),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ip(out_ip1),
    .out_ip_plus_one(out_ip_plus_one1), .out_word(out_word1), .level(level1));

  processor_fetch_queue #(.ADDR_SIZE(18), .WORD_SIZE(18), .DEPTH(4), .RESET_IP(18'h3FFFE)) dut2 (
    .clock(clock), .reset(reset), .code_addr(code_addr2), .code_word(code_word2),
    .hold(hold), .call_performed(call_performed), .ip_to_call(ip_to_call),
    .out_valid(out_valid2), .out_ready(out_ready), .out_ip(out_ip2),
    .out_ip_plus_one(out_ip_plus_one2), .out_word(out_word2), .level(level2));

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Leaves reset low 1 time unit after the last reset edge.
  task automatic do_reset();
    reset = 1'b1; hold = 1'b0; call_performed = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; hold = 1'b0; call_performed = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    total++; if (out_valid1 !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid1); else passed++;
    total++; if (level1 !== 3'd0) $display("FAIL reset_level got %0d want 0", level1); else passed++;
    total++; if (code_addr1 !== 18'h0) $display("FAIL reset_addr1 got %h want 0", code_addr1); else passed++;
    total++; if (code_addr2 !== 18'h3FFFE) $display("FAIL reset_addr2 got %h want 3fffe", code_addr2); else passed++;
    total++; if ({out_ip1, out_ip_plus_one1, out_word1} !== 54'h0)
      $display("FAIL reset_outs got %h/%h/%h want 0", out_ip1, out_ip_plus_one1, out_word1); else passed++;
  endtask

  task automatic test_stream();
    logic [17:0] e;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) exp_q.push_back(18'(i));
    step();
    total++; if (out_valid1 !== 1'b0) $display("FAIL stream_latency valid got %0b want 0", out_valid1); else passed++;
    step();
    for (int c = 0; c < 10; c++) begin
      e = exp_q.pop_front();
      total++;
      if (out_valid1 !== 1'b1 || {out_ip1, out_ip_plus_one1, out_word1} !== {e, e + 18'd1, e + 18'd100})
        $display("FAIL stream valid=%0b ip=%h ip1=%h word=%h want ip=%h", out_valid1, out_ip1, out_ip_plus_one1, out_word1, e);
      else passed++;
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] e;
    out_ready = 1'b0;
    do_reset();
    repeat (10) step();
    total++; if (level1 !== 3'd4) $display("FAIL bp_level got %0d want 4", level1); else passed++;
    total++; if (code_addr1 !== 18'd4) $display("FAIL bp_addr got %h want 4", code_addr1); else passed++;
    for (int i = 0; i < 8; i++) exp_q.push_back(18'(i));
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (out_valid1) begin
        e = exp_q.pop_front();
        total++;
        if ({out_ip1, out_word1} !== {e, e + 18'd100})
          $display("FAIL bp_order ip=%h word=%h want ip=%h", out_ip1, out_word1, e);
        else passed++;
      end
      step();
    end
    total++; if (exp_q.size() != 0) $display("FAIL bp_timeout left %0d want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_redirect();
    logic [17:0] e;
    int w;
    out_ready = 1'b0;
    do_reset();
    for (w = 0; w < 20 && level1 != 3'd3; w++) step();
    total++; if (level1 !== 3'd3) $display("FAIL redir_fill level got %0d want 3", level1); else passed++;
    call_performed = 1'b1; ip_to_call = 18'h200; out_ready = 1'b1;
    #1;
    total++; if (code_addr1 !== 18'h200) $display("FAIL redir_addr got %h want 200", code_addr1); else passed++;
    step();
    call_performed = 1'b0;
    total++; if (level1 !== 3'd0 || out_valid1 !== 1'b0)
      $display("FAIL redir_flush level=%0d valid=%0b want 0/0", level1, out_valid1); else passed++;
    for (int i = 0; i < 6; i++) exp_q.push_back(18'h200 + 18'(i));
    step();
    for (int c = 0; c < 6; c++) begin
      e = exp_q.pop_front();
      total++;
      if (out_valid1 !== 1'b1 || {out_ip1, out_word1} !== {e, e + 18'd100})
        $display("FAIL redir_stream valid=%0b ip=%h word=%h want ip=%h", out_valid1, out_ip1, out_word1, e);
      else passed++;
      step();
    end
  endtask

  task automatic test_hold();
    logic [17:0] e;
    out_ready = 1'b0;
    do_reset();
    step();
    hold = 1'b1;
    step();
    total++; if (level1 !== 3'd1 || out_ip1 !== 18'h0)
      $display("FAIL hold_inflight level=%0d ip=%h want 1/0", level1, out_ip1); else passed++;
    repeat (3) step();
    total++; if (code_addr1 !== 18'd1 || level1 !== 3'd1)
      $display("FAIL hold_stall addr=%h level=%0d want 1/1", code_addr1, level1); else passed++;
    call_performed = 1'b1; ip_to_call = 18'h40;
    #1;
    total++; if (code_addr1 !== 18'h40) $display("FAIL hold_redir_addr got %h want 40", code_addr1); else passed++;
    step();
    call_performed = 1'b0;
    repeat (2) step();
    total++; if (code_addr1 !== 18'h40 || out_valid1 !== 1'b0)
      $display("FAIL hold_redir_wait addr=%h valid=%0b want 40/0", code_addr1, out_valid1); else passed++;
    for (int i = 0; i < 5; i++) exp_q.push_back(18'h40 + 18'(i));
    hold = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 15 && exp_q.size() > 0; c++) begin
      if (out_valid1) begin
        e = exp_q.pop_front();
        total++;
        if ({out_ip1, out_word1} !== {e, e + 18'd100})
          $display("FAIL hold_resume ip=%h word=%h want ip=%h", out_ip1, out_word1, e);
        else passed++;
      end
      step();
    end
    total++; if (exp_q.size() != 0) $display("FAIL hold_timeout left %0d want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_wrap();
    logic [17:0] e;
    out_ready = 1'b1;
    do_reset();
    exp_q.push_back(18'h3FFFE); exp_q.push_back(18'h3FFFF);
    exp_q.push_back(18'h00000); exp_q.push_back(18'h00001);
    for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
      if (out_valid2) begin
        e = exp_q.pop_front();
        total++;
        if ({out_ip2, out_ip_plus_one2, out_word2} !== {e, e + 18'd1, e + 18'd100})
          $display("FAIL wrap ip=%h ip1=%h word=%h want ip=%h", out_ip2, out_ip_plus_one2, out_word2, e);
        else passed++;
      end
      step();
    end
    total++; if (exp_q.size() != 0) $display("FAIL wrap_timeout left %0d want 0", exp_q.size()); else passed++;
  endtask

  task automatic test_midstream_reset();
    logic [17:0] e;
    int w;
    out_ready = 1'b0;
    do_reset();
    for (w = 0; w < 20 && level1 != 3'd3; w++) step();
    total++; if (level1 !== 3'd3) $display("FAIL mreset_fill level got %0d want 3", level1); else passed++;
    reset = 1'b1;
    step();
    total++; if (out_valid1 !== 1'b0 || level1 !== 3'd0 || code_addr1 !== 18'h0)
      $display("FAIL mreset valid=%0b level=%0d addr=%h want 0/0/0", out_valid1, level1, code_addr1); else passed++;
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(18'(i));
    for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
      if (out_valid1) begin
        e = exp_q.pop_front();
        total++;
        if ({out_ip1, out_word1} !== {e, e + 18'd100})
          $display("FAIL mreset_restart ip=%h word=%h want ip=%h", out_ip1, out_word1, e);
        else passed++;
      end
      step();
    end
    total++; if (exp_q.size() != 0) $display("FAIL mreset_timeout left %0d want 0", exp_q.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_hold();
    test_wrap();
    test_midstream_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
